rd_engine_sequencer: RTL and testbench

//  Control stage directly upstream of the AXI read master engine. Captures a read-test config from the

---
 rtl/rd_engine_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_rd_engine_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_engine_sequencer.sv
// Sequencer in front of the AXI read master engine: launches N strided read runs, collects
// done/error/timeout and reports sticky status, a cycle count and an interrupt to the register block.
module rd_engine_sequencer #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 48,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_clear,
  input  logic [63:0]           cfg_source_address,
  input  logic [31:0]           cfg_addr_stride,
  input  logic [15:0]           cfg_loops,
  input  logic [31:0]           cfg_rd_number,
  input  logic [31:0]           cfg_rd_pattern,
  input  logic [31:0]           cfg_rd_init_data,
  input  logic                  cfg_wrap_mode,
  input  logic [3:0]            cfg_wrap_len,
  input  logic [31:0]           cfg_timeout,
  output logic                  engine_start_pulse,
  output logic [ADDR_WIDTH-1:0] source_address,
  output logic [31:0]           rd_pattern,
  output logic [31:0]           rd_number,
  output logic [31:0]           rd_init_data,
  output logic                  wrap_mode,
  output logic [3:0]            wrap_len,
  input  logic                  rd_done_pulse,
  input  logic [1:0]            rd_error,
  input  logic [63:0]           rd_error_info,
  output logic                  busy,
  output logic                  irq_pulse,
  output logic                  stat_done,
  output logic [1:0]            stat_error,
  output logic                  stat_timeout,
  output logic [63:0]           stat_error_info,
  output logic [15:0]           stat_iter,
  output logic [CNT_WIDTH-1:0]  stat_cycles
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state;
  logic [15:0]        iter_left;
  logic [31:0]        stride_r;
  logic [31:0]        timeout_r;
  logic [31:0]        timer;
  logic [GAP_W-1:0]   gap_cnt;

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      iter_left          <= '0;
      stride_r           <= '0;
      timeout_r          <= '0;
      timer              <= '0;
      gap_cnt            <= '0;
      engine_start_pulse <= 1'b0;
      source_address     <= '0;
      rd_pattern         <= '0;
      rd_number          <= '0;
      rd_init_data       <= '0;
      wrap_mode          <= 1'b0;
      wrap_len           <= '0;
      busy               <= 1'b0;
      irq_pulse          <= 1'b0;
      stat_done          <= 1'b0;
      stat_error         <= '0;
      stat_timeout       <= 1'b0;
      stat_error_info    <= '0;
      stat_iter          <= '0;
      stat_cycles        <= '0;
    end else begin
      engine_start_pulse <= 1'b0;
      irq_pulse          <= 1'b0;

      if (state != S_IDLE && stat_cycles != '1)
        stat_cycles <= stat_cycles + CNT_WIDTH'(1);

      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            source_address  <= ADDR_WIDTH'(cfg_source_address);
            rd_pattern      <= cfg_rd_pattern;
            rd_number       <= cfg_rd_number;
            rd_init_data    <= cfg_rd_init_data;
            wrap_mode       <= cfg_wrap_mode;
            wrap_len        <= cfg_wrap_len;
            stride_r        <= cfg_addr_stride;
            timeout_r       <= cfg_timeout;
            iter_left       <= (cfg_loops == 16'd0) ? 16'd1 : cfg_loops;
            stat_error      <= '0;
            stat_timeout    <= 1'b0;
            stat_error_info <= '0;
            stat_iter       <= '0;
            stat_cycles     <= '0;
            busy            <= 1'b1;
            // With zero bursts the engine never signals done, so finish immediately.
            if (cfg_rd_number == 32'd0) begin
              state     <= S_DONE;
              irq_pulse <= 1'b1;
              stat_done <= 1'b1;
            end else begin
              state              <= S_LAUNCH;
              engine_start_pulse <= 1'b1;
              stat_done          <= 1'b0;
            end
          end else if (cfg_clear) begin
            stat_done       <= 1'b0;
            stat_error      <= '0;
            stat_timeout    <= 1'b0;
            stat_error_info <= '0;
            stat_iter       <= '0;
            stat_cycles     <= '0;
          end
        end

        S_LAUNCH: begin
          timer <= '0;
          state <= S_RUN;
        end

        S_RUN: begin
          if (rd_done_pulse) begin
            stat_iter  <= stat_iter + 16'd1;
            stat_error <= stat_error | rd_error;
            if (stat_error == 2'b00 && rd_error != 2'b00)
              stat_error_info <= rd_error_info;
            if (rd_error != 2'b00 || iter_left == 16'd1) begin
              state     <= S_DONE;
              irq_pulse <= 1'b1;
              stat_done <= 1'b1;
            end else begin
              iter_left <= iter_left - 16'd1;
              gap_cnt   <= GAP_W'(GAP_CYCLES - 1);
              state     <= S_GAP;
            end
          end else if (timeout_r != 32'd0 && (timer + 32'd1) == timeout_r) begin
            stat_timeout <= 1'b1;
            state        <= S_DONE;
            irq_pulse    <= 1'b1;
            stat_done    <= 1'b1;
          end else begin
            timer <= timer + 32'd1;
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            source_address     <= source_address + ADDR_WIDTH'(stride_r);
            engine_start_pulse <= 1'b1;
            state              <= S_LAUNCH;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_engine_sequencer.sv
// Bench for rd_engine_sequencer: emulates the read engine with per-iteration latency/error tables and
// checks every run against an iteration-level model of launches, status and cycle totals.
module tb_rd_engine_sequencer;

  localparam int unsigned GAP = 4;
  localparam int unsigned MAXI = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start, cfg_clear;
  logic [63:0] cfg_source_address;
  logic [31:0] cfg_addr_stride;
  logic [15:0] cfg_loops;
  logic [31:0] cfg_rd_number, cfg_rd_pattern, cfg_rd_init_data;
  logic        cfg_wrap_mode;
  logic [3:0]  cfg_wrap_len;
  logic [31:0] cfg_timeout;
  logic        engine_start_pulse;
  logic [63:0] source_address;
  logic [31:0] rd_pattern, rd_number, rd_init_data;
  logic        wrap_mode;
  logic [3:0]  wrap_len;
  logic        rd_done_pulse;
  logic [1:0]  rd_error;
  logic [63:0] rd_error_info;
  logic        busy, irq_pulse, stat_done, stat_timeout;
  logic [1:0]  stat_error;
  logic [63:0] stat_error_info;
  logic [15:0] stat_iter;
  logic [47:0] stat_cycles;

  always #5 clk = ~clk;

  rd_engine_sequencer #(.ADDR_WIDTH(64), .CNT_WIDTH(48), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_clear(cfg_clear),
    .cfg_source_address(cfg_source_address), .cfg_addr_stride(cfg_addr_stride),
    .cfg_loops(cfg_loops), .cfg_rd_number(cfg_rd_number), .cfg_rd_pattern(cfg_rd_pattern),
    .cfg_rd_init_data(cfg_rd_init_data), .cfg_wrap_mode(cfg_wrap_mode), .cfg_wrap_len(cfg_wrap_len),
    .cfg_timeout(cfg_timeout), .engine_start_pulse(engine_start_pulse),
    .source_address(source_address), .rd_pattern(rd_pattern), .rd_number(rd_number),
    .rd_init_data(rd_init_data), .wrap_mode(wrap_mode), .wrap_len(wrap_len),
    .rd_done_pulse(rd_done_pulse), .rd_error(rd_error), .rd_error_info(rd_error_info),
    .busy(busy), .irq_pulse(irq_pulse), .stat_done(stat_done), .stat_error(stat_error),
    .stat_timeout(stat_timeout), .stat_error_info(stat_error_info), .stat_iter(stat_iter),
    .stat_cycles(stat_cycles)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Test configuration and per-iteration engine behaviour.
  logic [63:0] t_base;
  logic [31:0] t_stride, t_num, t_pat, t_init, t_tmo;
  logic [15:0] t_loops;
  logic        t_wm;
  logic [3:0]  t_wl;
  int unsigned lat [MAXI];
  logic [1:0]  er  [MAXI];
  logic [63:0] inf [MAXI];
  int          eng_cnt = 0;
  int          eng_idx = 0;

  task automatic engine_tick();
    rd_done_pulse = 1'b0;
    rd_error      = 2'($urandom);
    rd_error_info = {$urandom, $urandom};
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        rd_done_pulse = 1'b1;
        rd_error      = er[eng_idx];
        rd_error_info = inf[eng_idx];
      end
    end
  endtask

  task automatic drive_cfg();
    cfg_source_address = t_base;
    cfg_addr_stride    = t_stride;
    cfg_loops          = t_loops;
    cfg_rd_number      = t_num;
    cfg_rd_pattern     = t_pat;
    cfg_rd_init_data   = t_init;
    cfg_wrap_mode      = t_wm;
    cfg_wrap_len       = t_wl;
    cfg_timeout        = t_tmo;
  endtask

  task automatic noise_cfg();
    cfg_source_address = {$urandom, $urandom};
    cfg_addr_stride    = $urandom;
    cfg_loops          = 16'($urandom);
    cfg_rd_number      = $urandom;
    cfg_rd_pattern     = $urandom;
    cfg_rd_init_data   = $urandom;
    cfg_wrap_mode      = 1'($urandom);
    cfg_wrap_len       = 4'($urandom);
    cfg_timeout        = $urandom;
    cfg_start          = ($urandom % 4) == 0;
    cfg_clear          = 1'($urandom);
  endtask

  task automatic run_seq(input string nm, input bit noise);
    int          n, starts, irqs;
    bit          seen, ended;
    logic [63:0] e_cycles, e_info, e_last, a;
    logic [1:0]  e_err;
    int          e_iter, e_starts;
    bit          e_to;
    // Iteration-level model: each launch costs 1 cycle, the engine latency (or the timeout)
    // in RUN cycles, GAP between iterations, and one final DONE cycle.
    n = (t_loops == 16'd0) ? 1 : int'(t_loops);
    e_cycles = 0; e_info = 0; e_err = 0; e_iter = 0; e_starts = 0; e_to = 0; e_last = t_base;
    if (t_num == 32'd0) e_cycles = 1;
    else begin
      for (int i = 0; i < n; i++) begin
        e_starts++;
        e_last = t_base + 64'(i) * 64'(t_stride);
        e_cycles += 1;
        if (t_tmo != 32'd0 && 64'(lat[i]) > 64'(t_tmo)) begin
          e_cycles += 64'(t_tmo); e_to = 1; break;
        end
        e_cycles += 64'(lat[i]);
        e_iter++;
        if (e_err == 2'b00 && er[i] != 2'b00) e_info = inf[i];
        e_err |= er[i];
        if (er[i] != 2'b00 || i == n - 1) break;
        e_cycles += 64'(GAP);
      end
      e_cycles += 1;
    end

    @(negedge clk);
    drive_cfg();
    cfg_start = 1'b1;
    cfg_clear = noise ? 1'($urandom) : 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_clear = 1'b0;
    starts = 0; irqs = 0; seen = 0; ended = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      engine_tick();
      if (engine_start_pulse) begin
        a = t_base + 64'(starts) * 64'(t_stride);
        check({nm, "_addr"}, source_address, a);
        check({nm, "_ctl"}, {rd_number, rd_pattern}, {t_num, t_pat});
        check({nm, "_ctl2"}, {27'd0, wrap_mode, wrap_len, rd_init_data}, {27'd0, t_wm, t_wl, t_init});
        if (starts < int'(MAXI)) begin
          eng_idx = starts;
          eng_cnt = int'(lat[starts]);
        end
        starts++;
      end
      if (irq_pulse) irqs++;
      if (busy) seen = 1;
      else if (seen) begin ended = 1; break; end
      if (noise && busy) noise_cfg();
      @(negedge clk);
    end
    cfg_start = 1'b0;
    cfg_clear = 1'b0;
    drive_cfg();
    check({nm, "_ended"}, 64'(ended), 64'd1);
    check({nm, "_starts"}, 64'(starts), 64'(e_starts));
    check({nm, "_irqs"}, 64'(irqs), 64'd1);
    check({nm, "_done"}, 64'(stat_done), 64'd1);
    check({nm, "_iter"}, 64'(stat_iter), 64'(e_iter));
    check({nm, "_err"}, 64'(stat_error), 64'(e_err));
    check({nm, "_tmo"}, 64'(stat_timeout), 64'(e_to));
    check({nm, "_info"}, stat_error_info, e_info);
    check({nm, "_cycles"}, 64'(stat_cycles), e_cycles);
    check({nm, "_lastaddr"}, source_address, e_last);
    // Late engine completions after the run must leave status untouched.
    for (int k = 0; k < 40; k++) begin
      engine_tick();
      @(negedge clk);
    end
    eng_cnt = 0;
    rd_done_pulse = 1'b0;
    check({nm, "_post"}, {47'd0, busy, stat_iter}, {47'd0, 1'b0, 16'(e_iter)});
  endtask

  task automatic clear_tables();
    for (int i = 0; i < int'(MAXI); i++) begin
      lat[i] = 5; er[i] = 2'b00; inf[i] = 64'd0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_clear = 1'b0;
    rd_done_pulse = 1'b0; rd_error = 2'b00; rd_error_info = 64'd0;
    t_base = 0; t_stride = 0; t_num = 0; t_pat = 0; t_init = 0; t_tmo = 0;
    t_loops = 0; t_wm = 0; t_wl = 0;
    drive_cfg();
    clear_tables();
    repeat (3) @(negedge clk);
    check("reset_ctl", {busy, engine_start_pulse, irq_pulse, stat_done, stat_timeout, stat_error,
                        stat_iter}, 64'd0);
    check("reset_cyc", 64'(stat_cycles), 64'd0);
    rst_n = 1'b1;

    // Single iteration, engine answers 20 cycles after start.
    clear_tables();
    t_loops = 1; t_num = 4; t_base = 64'h8000; t_stride = 32'h40; t_pat = 32'h0010_0302;
    t_init = 32'hA5A5_0001; t_wm = 1; t_wl = 4'h7; t_tmo = 0; lat[0] = 20;
    run_seq("one", 1'b0);
    check("one_cycles22", 64'(stat_cycles), 64'd22);

    // Three strided iterations.
    clear_tables();
    t_loops = 3; t_base = 64'h1000; t_stride = 32'h200; lat[0] = 7; lat[1] = 3; lat[2] = 11;
    run_seq("stride", 1'b0);
    check("stride_iter3", 64'(stat_iter), 64'd3);

    // Error on the second iteration stops the sequence.
    clear_tables();
    t_loops = 3; er[1] = 2'b10; inf[1] = 64'hDEAD; lat[1] = 9;
    run_seq("error", 1'b0);
    check("error_info", stat_error_info, 64'hDEAD);

    // Engine never answers; timeout at 50.
    clear_tables();
    t_loops = 2; t_tmo = 50; lat[0] = 1000;
    run_seq("timeout", 1'b0);
    check("timeout_cycles", 64'(stat_cycles), 64'd52);
    t_tmo = 0;

    // Zero bursts: immediate DONE; noise and restarts while busy are ignored.
    clear_tables();
    t_loops = 5; t_num = 0;
    run_seq("zero", 1'b1);

    // Clear in IDLE zeroes status but keeps control outputs.
    clear_tables();
    t_loops = 2; t_num = 9; er[0] = 2'b01; inf[0] = 64'h1234_5678_9ABC_DEF0;
    run_seq("pre_clr", 1'b0);
    @(negedge clk); cfg_clear = 1'b1;
    @(negedge clk); cfg_clear = 1'b0;
    check("clr_stat", {stat_done, stat_timeout, stat_error, stat_iter}, 64'd0);
    check("clr_stat2", stat_error_info | 64'(stat_cycles), 64'd0);
    check("clr_keep", {rd_number, source_address[31:0]}, {32'd9, t_base[31:0]});

    // Reset in the middle of a run.
    clear_tables();
    t_loops = 2; t_num = 3; t_base = 64'hFFFF_0000; lat[0] = 200;
    @(negedge clk); drive_cfg(); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctl", {busy, engine_start_pulse, irq_pulse, stat_done, stat_iter,
                          rd_number[7:0]}, 64'd0);
    check("rst_mid_addr", source_address | 64'(stat_cycles), 64'd0);
    @(negedge clk); rst_n = 1'b1; eng_cnt = 0;
    clear_tables();
    t_loops = 1; t_num = 1; lat[0] = 4;
    run_seq("after_rst", 1'b0);

    // Randomized sequences with input noise while busy.
    for (int r = 0; r < 40; r++) begin
      t_loops  = 16'($urandom_range(0, 6));
      t_num    = (($urandom % 6) == 0) ? 32'd0 : $urandom;
      t_base   = {$urandom, $urandom};
      t_stride = $urandom;
      t_pat    = $urandom; t_init = $urandom; t_wm = 1'($urandom); t_wl = 4'($urandom);
      for (int i = 0; i < int'(MAXI); i++) begin
        lat[i] = $urandom_range(1, 30);
        er[i]  = (($urandom % 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        inf[i] = {$urandom, $urandom};
      end
      case ($urandom % 3)
        0: t_tmo = 0;
        1: t_tmo = $urandom_range(1, 30);
        default: t_tmo = lat[$urandom_range(0, 2)];
      endcase
      run_seq("rand", 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
